dmem_lsu_ctrl: RTL and testbench
================================

// Module: dmem_lsu_ctrl
// PURPOSE
//  Load/store sequencer between the pipeline MEM stage and the byte-wide data memory (8-bit port, 1 byte write/cycle, async read + 4-byte word view).
//  Accepts byte/half/word requests over a valid/ready handshake.
//  Stores: issues one byte write per cycle, little-endian. Loads: returns sign/zero-extended 32-bit data.
//  Flags misaligned accesses.
// PARAMETERS
//  ADDR_WIDTH  11  byte address width of the data memory
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   controller can accept (IDLE only)
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
//  req_unsigned  in   1   load zero-extends when 1
//  req_addr      in   ADDR_WIDTH  byte address
//  req_wdata     in   32  store data, byte0 = [7:0]
//  rsp_valid     out  1   1-cycle response pulse
//  rsp_err       out  1   misaligned/illegal, qualified by rsp_valid
//  rsp_rdata     out  32  load data, 0 for stores/errors, qualified by rsp_valid
//  dmem_w_en     out  1   memory byte write enable
//  dmem_addr     out  ADDR_WIDTH  memory byte address
//  dmem_w_data   out  8   memory write byte
//  dmem_r_data   in   8   memory byte at dmem_addr
//  dmem_byte0..3 in   8   bytes of aligned word containing dmem_addr
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dmem_w_en=0, dmem_addr=0, dmem_w_data=0. All outputs registered except req_ready (=state==IDLE).
//  FSM IDLE->{STORE,LOAD,RESP}, STORE->RESP, LOAD->RESP, RESP->IDLE.
//  Accept on req_valid&&req_ready: latch addr/size/we/unsigned/wdata, cnt=0, N=1/2/4.
//  Misalign: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//    -> RESP with rsp_err=1, no write. Response at T+1 for acceptance at T.
//  STORE: cycles T+1..T+N: dmem_w_en=1, dmem_addr=base+cnt (wraps mod 2^ADDR_WIDTH), dmem_w_data=wdata[8*cnt+:8]; cnt++.
//    RESP at T+N+1 with rsp_rdata=0.
//  LOAD (aligned): cycle T+1: dmem_addr=base; select bytes from dmem_byte0..3 by addr[1:0]; extend (bit 7/15 sign unless unsigned).
//    Register the result; RESP at T+2.
//  RESP: rsp_valid=1 for exactly one cycle; next cycle IDLE. Earliest next accept is the cycle after RESP.
//  req_* ignored outside IDLE; requester holds them until req_ready.
//  dmem_w_en is 0 in every state except STORE.
//  Reset mid-operation: immediate return to IDLE, dmem_w_en drops asynchronously.
//    Already-written bytes stay written; no response is issued.
//  Memory write and read of the same cycle never overlap (single port sequencing).
// CONFIGURATION
//  LSU_MISALIGN_EN defined: misaligned half/word are legal (size=11 still errors).
//    Stores: same byte sequence; address wraps across 2^ADDR_WIDTH.
//    Misaligned loads: LOAD for N cycles, dmem_addr=base+cnt, accumulate dmem_r_data into byte cnt, then extend.
//    Response at T+N+1.
//  Not defined: misaligned accesses get the rsp_err response as above.
// TESTING
//  SW 0xA1B2C3D4 @0x010 -> writes D4@010,C3@011,B2@012,A1@013 in 4 consecutive cycles, rsp_valid 5 cycles after accept, rsp_err=0
//  LB @0x012 (signed) after above -> rsp_rdata=0xFFFFFFB2 two cycles after accept; LBU -> 0x000000B2
//  LH @0x012 signed -> 0xFFFFA1B2; LW @0x010 -> 0xA1B2C3D4; no dmem_w_en during loads
//  SH @0x011 without macro -> rsp_err=1 one cycle after accept, no write; with LSU_MISALIGN_EN -> writes @011,@012
//  SW 0x11223344 @0x7FE with LSU_MISALIGN_EN -> bytes to 7FE,7FF,000,001 (wrap); LW back @0x7FE -> 0x11223344 at T+5
//  Assert rst during 2nd byte of SW -> dmem_w_en=0 same cycle, req_ready=1, no rsp_valid, bytes 3-4 unwritten

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for a byte-wide data memory with a word read view.
// Optional LSU_MISALIGN_EN makes misaligned half/word accesses legal.
module dmem_lsu_ctrl #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  dmem_w_en,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [7:0]            dmem_w_data,
  input  logic [7:0]            dmem_r_data,
  input  logic [7:0]            dmem_byte0,
  input  logic [7:0]            dmem_byte1,
  input  logic [7:0]            dmem_byte2,
  input  logic [7:0]            dmem_byte3
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [31:0]             wdata_q;
  logic [1:0]              cnt_q, cnt_n, nxt, last_q;
  logic                    mis_req;
  logic [31:0]             word_sh, raw;
  logic                    w_en_n, rv_n, err_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [7:0]              wd_n;
  logic [31:0]             rdata_n;
`ifdef LSU_MISALIGN_EN
  logic [31:0]             acc_q, acc_n;
  logic                    unal_q;
`endif

  function automatic logic [31:0] ext(
    input logic [31:0] r,
    input logic [1:0]  sz,
    input logic        u
  );
    logic s;
    s   = 1'b0;
    ext = r;
    case (sz)
      2'b00: begin
        s   = ~u & r[7];
        ext = {{24{s}}, r[7:0]};
      end
      2'b01: begin
        s   = ~u & r[15];
        ext = {{16{s}}, r[15:0]};
      end
      default: ext = r;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign nxt       = cnt_q + 2'd1;
  assign last_q    = (size_q == 2'b00) ? 2'd0 :
                     (size_q == 2'b01) ? 2'd1 : 2'd3;

`ifdef LSU_MISALIGN_EN
  assign mis_req = (req_size == 2'b11);
  assign unal_q  = ((size_q == 2'b01) & base_q[0]) |
                   ((size_q == 2'b10) & (base_q[1:0] != 2'b00));
`else
  assign mis_req = (req_size == 2'b11) |
                   ((req_size == 2'b01) & req_addr[0]) |
                   ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`endif

  // Word view shifted so the addressed byte lands in bits [7:0]
  assign word_sh = {dmem_byte3, dmem_byte2, dmem_byte1, dmem_byte0}
                   >> {base_q[1:0], 3'b000};
  assign raw     = (size_q == 2'b00) ? {24'b0, dmem_r_data} : word_sh;

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    w_en_n  = 1'b0;
    rv_n    = 1'b0;
    err_n   = 1'b0;
    addr_n  = dmem_addr;
    wd_n    = dmem_w_data;
    rdata_n = 32'b0;
`ifdef LSU_MISALIGN_EN
    acc_n   = acc_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_n  = 2'd0;
          addr_n = req_addr;
`ifdef LSU_MISALIGN_EN
          acc_n  = 32'b0;
`endif
          if (mis_req) begin
            state_n = RESP;
            rv_n    = 1'b1;
            err_n   = 1'b1;
            addr_n  = dmem_addr;
          end else if (req_we) begin
            state_n = STORE;
            w_en_n  = 1'b1;
            wd_n    = req_wdata[7:0];
          end else begin
            state_n = LOAD;
          end
        end
      end
      STORE: begin
        if (cnt_q == last_q) begin
          state_n = RESP;
          rv_n    = 1'b1;
        end else begin
          cnt_n  = nxt;
          w_en_n = 1'b1;
          addr_n = base_q + ADDR_WIDTH'(nxt);
          wd_n   = wdata_q[8*nxt +: 8];
        end
      end
      LOAD: begin
`ifdef LSU_MISALIGN_EN
        if (unal_q) begin
          acc_n[8*cnt_q +: 8] = dmem_r_data;
          if (cnt_q == last_q) begin
            state_n = RESP;
            rv_n    = 1'b1;
            rdata_n = ext(acc_n, size_q, uns_q);
          end else begin
            cnt_n  = nxt;
            addr_n = base_q + ADDR_WIDTH'(nxt);
          end
        end else begin
          state_n = RESP;
          rv_n    = 1'b1;
          rdata_n = ext(raw, size_q, uns_q);
        end
`else
        state_n = RESP;
        rv_n    = 1'b1;
        rdata_n = ext(raw, size_q, uns_q);
`endif
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_q       <= 2'd0;
      base_q      <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'b0;
      dmem_w_en   <= 1'b0;
      dmem_addr   <= '0;
      dmem_w_data <= 8'b0;
`ifdef LSU_MISALIGN_EN
      acc_q       <= 32'b0;
`endif
    end else begin
      state       <= state_n;
      cnt_q       <= cnt_n;
      rsp_valid   <= rv_n;
      rsp_err     <= err_n;
      rsp_rdata   <= rdata_n;
      dmem_w_en   <= w_en_n;
      dmem_addr   <= addr_n;
      dmem_w_data <= wd_n;
`ifdef LSU_MISALIGN_EN
      acc_q       <= acc_n;
`endif
      if (state == IDLE && req_valid) begin
        base_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard/table bench for dmem_lsu_ctrl with a behavioural byte memory.
// Expectations follow LSU_MISALIGN_EN when it is defined.
module tb_dmem_lsu_ctrl;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        dmem_w_en;
  logic [10:0] dmem_addr;
  logic [7:0]  dmem_w_data, dmem_r_data;
  logic [7:0]  dmem_byte0, dmem_byte1, dmem_byte2, dmem_byte3;

  logic [7:0]  mem [2048] = '{default: 8'h00};

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  vec_t vt[$];
  exp_t sbq[$];
  wr_t  wlog[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   in_load = 1'b0;

  dmem_lsu_ctrl #(.ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .dmem_w_en(dmem_w_en), .dmem_addr(dmem_addr),
    .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data),
    .dmem_byte0(dmem_byte0), .dmem_byte1(dmem_byte1),
    .dmem_byte2(dmem_byte2), .dmem_byte3(dmem_byte3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (dmem_w_en) mem[dmem_addr] <= dmem_w_data;

  assign dmem_r_data = mem[dmem_addr];
  assign dmem_byte0  = mem[{dmem_addr[10:2], 2'd0}];
  assign dmem_byte1  = mem[{dmem_addr[10:2], 2'd1}];
  assign dmem_byte2  = mem[{dmem_addr[10:2], 2'd2}];
  assign dmem_byte3  = mem[{dmem_addr[10:2], 2'd3}];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t V(input logic we, input logic [1:0] sz,
                             input logic u, input logic [10:0] a,
                             input logic [31:0] wd, input logic e,
                             input logic [31:0] rd, input int l);
    vec_t v;
    v.we = we; v.size = sz; v.uns = u; v.addr = a;
    v.wdata = wd; v.err = e; v.rdata = rd; v.lat = l;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_w_en) wlog.push_back('{dmem_addr, dmem_w_data, cyc});
      if (in_load) chk("no_write_on_load", {31'b0, dmem_w_en}, 32'd0);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("v%0d_err", e.id), {31'b0, rsp_err},
              {31'b0, e.err});
          chk($sformatf("v%0d_rdata", e.id), rsp_rdata, e.rdata);
          chk($sformatf("v%0d_lat", e.id), cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    int n;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_accept", id), {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    sbq.push_back('{v.err, v.rdata, v.lat, cyc, id});
    req_valid = 1'b0;
    in_load = !v.we;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk($sformatf("v%0d_rsp_seen", id), sbq.size(), 0);
    sbq.delete();
    in_load = 1'b0;
  endtask

  initial begin
    int n;
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_w_en", {31'b0, dmem_w_en}, 32'd0);
    chk("rst_addr", {21'b0, dmem_addr}, 32'd0);
    chk("rst_w_data", {24'b0, dmem_w_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Word store: four consecutive byte writes, little-endian
    wlog.delete();
    run_vec(V(1, 2, 0, 'h010, 'hA1B2C3D4, 0, 0, 5), 100);
    chk("sw_nwrites", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      logic [31:0] wd;
      wd = 32'hA1B2C3D4;
      chk($sformatf("sw_addr%0d", k), {21'b0, wlog[k].addr}, 32'h010 + k);
      chk($sformatf("sw_data%0d", k), {24'b0, wlog[k].data},
          {24'b0, wd[8*k +: 8]});
      chk($sformatf("sw_cyc%0d", k), wlog[k].cyc, last_acc + k);
    end

    vt.push_back(V(0, 0, 0, 'h012, 0, 0, 'hFFFFFFB2, 2));
    vt.push_back(V(0, 0, 1, 'h012, 0, 0, 'h000000B2, 2));
    vt.push_back(V(0, 1, 0, 'h012, 0, 0, 'hFFFFA1B2, 2));
    vt.push_back(V(0, 1, 1, 'h010, 0, 0, 'h0000C3D4, 2));
    vt.push_back(V(0, 2, 0, 'h010, 0, 0, 'hA1B2C3D4, 2));
    vt.push_back(V(1, 1, 0, 'h011, 'h5566, !MIS, 0, MIS ? 3 : 1));
    vt.push_back(V(0, 0, 1, 'h011, 0, 0, MIS ? 'h66 : 'hC3, 2));
    vt.push_back(V(0, 0, 1, 'h013, 0, 0, 'hA1, 2));
    vt.push_back(V(0, 3, 0, 'h010, 0, 1, 0, 1));
    vt.push_back(V(1, 3, 0, 'h010, 'hFFFFFFFF, 1, 0, 1));
    vt.push_back(V(0, 2, 1, 'h010, 0, 0,
                   MIS ? 'hA15566D4 : 'hA1B2C3D4, 2));
    vt.push_back(V(1, 0, 0, 'h7FF, 'h7F, 0, 0, 2));
    vt.push_back(V(0, 0, 0, 'h7FF, 0, 0, 'h0000007F, 2));
    vt.push_back(V(1, 1, 0, 'h7FC, 'h8001, 0, 0, 3));
    vt.push_back(V(0, 1, 0, 'h7FC, 0, 0, 'hFFFF8001, 2));
    vt.push_back(V(0, 1, 1, 'h7FC, 0, 0, 'h00008001, 2));
    vt.push_back(V(0, 0, 0, 'h7FD, 0, 0, 'hFFFFFF80, 2));
    vt.push_back(V(0, 2, 0, 'h011, 0, !MIS,
                   MIS ? 'h00A15566 : 0, MIS ? 5 : 1));
    vt.push_back(V(1, 2, 0, 'h7FE, 'h11223344, !MIS, 0, MIS ? 5 : 1));
    vt.push_back(V(0, 2, 0, 'h7FE, 0, !MIS,
                   MIS ? 'h11223344 : 0, MIS ? 5 : 1));
    vt.push_back(V(0, 0, 1, 'h000, 0, 0, MIS ? 'h22 : 0, 2));
    vt.push_back(V(0, 1, 0, 'h001, 0, !MIS,
                   MIS ? 'h11 : 0, MIS ? 3 : 1));
    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Reset in the middle of a word store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 'h020; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!(dmem_w_en && dmem_addr == 11'h021) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", {31'b0, dmem_w_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_w_en", {31'b0, dmem_w_en}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mem020", {24'b0, mem[11'h020]}, 32'hEF);
    chk("rst_mem022", {24'b0, mem[11'h022]}, 32'h00);
    chk("rst_mem023", {24'b0, mem[11'h023]}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
